// File: rtl/ripple_count_monitor_if.sv
// Bundle of signals between the ripple counter monitor and its neighbours.
// Optional macro SEG7_EN adds the seven-segment output seg.
interface ripple_count_monitor_if #(
    parameter int Q_W    = 4,
    parameter int WRAP_W = 8
);
    logic [Q_W-1:0]    q_in;
    logic              clr;
    logic [Q_W-1:0]    match;
    logic [Q_W-1:0]    stable_q;
    logic              q_valid;
    logic              wrap;
    logic              match_hit;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              evt_valid;
    logic              evt_ready;
    logic [WRAP_W-1:0] evt_data;
    logic              overrun;
`ifdef SEG7_EN
    logic [6:0]        seg;
`endif

    // The monitor itself.
    modport slave (
        input  q_in, clr, match, evt_ready,
        output stable_q, q_valid, wrap, match_hit, wrap_cnt, evt_valid, evt_data, overrun
`ifdef SEG7_EN
        , output seg
`endif
    );

    // Whoever drives the counter value and consumes the events.
    modport master (
        output q_in, clr, match, evt_ready,
        input  stable_q, q_valid, wrap, match_hit, wrap_cnt, evt_valid, evt_data, overrun
`ifdef SEG7_EN
        , input seg
`endif
    );
endinterface

// File: rtl/ripple_count_monitor.sv
// Ripple counter monitor: synchronises an asynchronous counter value, accepts it
// only after it has been stable for STABLE_N samples, and reports commits, wraps
// (with a saturating tally and a one-entry event buffer) and compare matches.
// Optional macro SEG7_EN adds a registered hex seven-segment decode of stable_q.
module ripple_count_monitor #(
    parameter int Q_W      = 4,
    parameter int WRAP_W   = 8,
    parameter int STABLE_N = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    ripple_count_monitor_if.slave  mon
);
    localparam int CNT_W = (STABLE_N < 1) ? 1 : $clog2(STABLE_N + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_N);
    localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

    typedef enum logic {SETTLE = 1'b0, HOLD = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [Q_W-1:0]    s1_q, s2_q;
    logic [Q_W-1:0]    cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [Q_W-1:0]    stable_q_q, stable_q_d;
    logic              q_valid_q, q_valid_d;
    logic              wrap_q, wrap_d;
    logic              match_hit_q, match_hit_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              evt_valid_q, evt_valid_d;
    logic [WRAP_W-1:0] evt_data_q, evt_data_d;
    logic              overrun_q, overrun_d;
    logic              commit;
    logic [WRAP_W-1:0] wrap_inc;

    // Two-flop synchroniser; q_in is launched from the ripple counter, not this clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= mon.q_in;
            s2_q <= s1_q;
        end
    end

    // Filter, commit detection, tally and event buffer next-state logic.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        stable_q_d  = stable_q_q;
        commit      = 1'b0;
        wrap_cnt_d  = wrap_cnt_q;
        evt_valid_d = evt_valid_q;
        evt_data_d  = evt_data_q;
        overrun_d   = overrun_q;
        wrap_inc    = (wrap_cnt_q == WRAP_MAX) ? WRAP_MAX : wrap_cnt_q + 1'b1;

        if (s2_q != cand_q) begin
            // New candidate: restart the stability count.
            cand_d  = s2_q;
            cnt_d   = CNT_W'(1);
            state_d = SETTLE;
        end else begin
            if (cnt_q != CNT_MAX)
                cnt_d = cnt_q + 1'b1;
            // Commit only while the sample still agrees, so a value must be seen STABLE_N+1 times.
            if (state_q == SETTLE && cnt_q == CNT_MAX) begin
                state_d = HOLD;
                commit  = (cand_q != stable_q_q);
            end
        end

        if (commit)
            stable_q_d = cand_q;

        q_valid_d   = commit;
        wrap_d      = commit && (cand_q < stable_q_q);
        match_hit_d = commit && (cand_q == mon.match);

        if (mon.clr) begin
            // Clear wins; a wrap in this cycle is dropped from tally and buffer.
            wrap_cnt_d  = '0;
            overrun_d   = 1'b0;
            evt_valid_d = 1'b0;
        end else if (wrap_d) begin
            wrap_cnt_d = wrap_inc;
            if (!evt_valid_q || mon.evt_ready) begin
                evt_data_d  = wrap_inc;
                evt_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (evt_valid_q && mon.evt_ready) begin
            evt_valid_d = 1'b0;
        end
    end

    // State register for the filter, outputs and event buffer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= SETTLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            stable_q_q  <= '0;
            q_valid_q   <= 1'b0;
            wrap_q      <= 1'b0;
            match_hit_q <= 1'b0;
            wrap_cnt_q  <= '0;
            evt_valid_q <= 1'b0;
            evt_data_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            stable_q_q  <= stable_q_d;
            q_valid_q   <= q_valid_d;
            wrap_q      <= wrap_d;
            match_hit_q <= match_hit_d;
            wrap_cnt_q  <= wrap_cnt_d;
            evt_valid_q <= evt_valid_d;
            evt_data_q  <= evt_data_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mon.stable_q  = stable_q_q;
    assign mon.q_valid   = q_valid_q;
    assign mon.wrap      = wrap_q;
    assign mon.match_hit = match_hit_q;
    assign mon.wrap_cnt  = wrap_cnt_q;
    assign mon.evt_valid = evt_valid_q;
    assign mon.evt_data  = evt_data_q;
    assign mon.overrun   = overrun_q;

`ifdef SEG7_EN
    logic [6:0] seg_q, seg_d;

    // Hex decode (gfedcba, active-high) of the value being committed.
    always_comb begin
        seg_d = seg_q;
        if (commit) begin
            case (cand_q[3:0])
                4'h0: seg_d = 7'h3F;
                4'h1: seg_d = 7'h06;
                4'h2: seg_d = 7'h5B;
                4'h3: seg_d = 7'h4F;
                4'h4: seg_d = 7'h66;
                4'h5: seg_d = 7'h6D;
                4'h6: seg_d = 7'h7D;
                4'h7: seg_d = 7'h07;
                4'h8: seg_d = 7'h7F;
                4'h9: seg_d = 7'h6F;
                4'hA: seg_d = 7'h77;
                4'hB: seg_d = 7'h7C;
                4'hC: seg_d = 7'h39;
                4'hD: seg_d = 7'h5E;
                4'hE: seg_d = 7'h79;
                default: seg_d = 7'h71;
            endcase
        end
    end

    // Segment register, updated together with stable_q.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            seg_q <= 7'h3F;
        else
            seg_q <= seg_d;
    end

    assign mon.seg = seg_q;
`endif
endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor: main instance (WRAP_W=8) plus a
// WRAP_W=2 instance for tally saturation. Define SEG7_EN to also check seg.
module tb_ripple_count_monitor;
    logic clock = 1'b0;
    logic reset = 1'b0;

    ripple_count_monitor_if #(.Q_W(4), .WRAP_W(8)) bus ();
    ripple_count_monitor_if #(.Q_W(4), .WRAP_W(2)) bus2 ();

    ripple_count_monitor #(.Q_W(4), .WRAP_W(8), .STABLE_N(2)) dut (
        .clock (clock),
        .reset (reset),
        .mon   (bus)
    );

    ripple_count_monitor #(.Q_W(4), .WRAP_W(2), .STABLE_N(2)) dut2 (
        .clock (clock),
        .reset (reset),
        .mon   (bus2)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Pulse counters accumulated by run().
    int n_qv, n_wrap, n_mh, n_ev, n_wrap2;
    int last_evd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end else begin
            $display("check %s: got %0d ok", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clear_counts();
        n_qv = 0; n_wrap = 0; n_mh = 0; n_ev = 0; n_wrap2 = 0; last_evd = -1;
    endtask

    // Advance n cycles, counting pulses sampled just after each edge.
    task automatic run(input int n);
        repeat (n) begin
            tick(1);
            if (bus.q_valid)   n_qv++;
            if (bus.wrap)      n_wrap++;
            if (bus.match_hit) n_mh++;
            if (bus.evt_valid) begin
                n_ev++;
                last_evd = int'(bus.evt_data);
            end
            if (bus2.wrap)     n_wrap2++;
        end
    endtask

    task automatic pulse_clr();
        bus.clr = 1'b1;
        tick(1);
        bus.clr = 1'b0;
    endtask

    initial begin
        bus.q_in = 4'd9;  bus.clr = 1'b0; bus.match = 4'd0; bus.evt_ready = 1'b1;
        bus2.q_in = 4'd0; bus2.clr = 1'b0; bus2.match = 4'd0; bus2.evt_ready = 1'b1;
        clear_counts();

        // Reset state
        tick(3);
        check("rst_stable_q", 32'(bus.stable_q), 32'd0);
        check("rst_q_valid", 32'(bus.q_valid), 32'd0);
        check("rst_wrap_cnt", 32'(bus.wrap_cnt), 32'd0);
        check("rst_evt_valid", 32'(bus.evt_valid), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
`ifdef SEG7_EN
        check("rst_seg", 32'(bus.seg), 32'h3F);
`endif

        // 1: q_in=9 commits on edge 5 after release
        reset = 1'b1;
        tick(4);
        check("t1_edge4_stable_q", 32'(bus.stable_q), 32'd0);
        check("t1_edge4_q_valid", 32'(bus.q_valid), 32'd0);
        tick(1);
        check("t1_edge5_stable_q", 32'(bus.stable_q), 32'd9);
        check("t1_edge5_q_valid", 32'(bus.q_valid), 32'd1);
        check("t1_edge5_wrap", 32'(bus.wrap), 32'd0);
`ifdef SEG7_EN
        check("t1_seg9", 32'(bus.seg), 32'h6F);
`endif
        tick(1);
        check("t1_q_valid_drop", 32'(bus.q_valid), 32'd0);

        // 2: settle on 2, then a 2-cycle glitch to 3 must be ignored
        bus.q_in = 4'd2;
        run(10);
        check("t2_stable_2", 32'(bus.stable_q), 32'd2);
        pulse_clr();
        clear_counts();
        bus.q_in = 4'd3;
        tick(2);
        bus.q_in = 4'd2;
        run(10);
        check("t2_glitch_q_valid", 32'(n_qv), 32'd0);
        check("t2_glitch_stable_q", 32'(bus.stable_q), 32'd2);

        // 3: 14,15,0 with evt_ready=1 -> one wrap, tally 1, event data 1
        clear_counts();
        bus.q_in = 4'd14; run(10);
        bus.q_in = 4'd15; run(10);
        bus.q_in = 4'd0;  run(10);
        check("t3_q_valid_count", 32'(n_qv), 32'd3);
        check("t3_wrap_count", 32'(n_wrap), 32'd1);
        check("t3_wrap_cnt", 32'(bus.wrap_cnt), 32'd1);
        check("t3_evt_valid_cycles", 32'(n_ev), 32'd1);
        check("t3_evt_data", 32'(last_evd), 32'd1);
        check("t3_evt_drained", 32'(bus.evt_valid), 32'd0);

        // 4: evt_ready=0, two wraps -> overrun; then clr
        pulse_clr();
        bus.evt_ready = 1'b0;
        clear_counts();
        bus.q_in = 4'd5; run(10);
        bus.q_in = 4'd1; run(10);
        bus.q_in = 4'd5; run(10);
        bus.q_in = 4'd1; run(10);
        check("t4_wrap_count", 32'(n_wrap), 32'd2);
        check("t4_evt_valid", 32'(bus.evt_valid), 32'd1);
        check("t4_evt_data", 32'(bus.evt_data), 32'd1);
        check("t4_overrun", 32'(bus.overrun), 32'd1);
        check("t4_wrap_cnt", 32'(bus.wrap_cnt), 32'd2);
`ifdef SEG7_EN
        check("t4_seg1", 32'(bus.seg), 32'h06);
`endif
        pulse_clr();
        check("t4_clr_wrap_cnt", 32'(bus.wrap_cnt), 32'd0);
        check("t4_clr_overrun", 32'(bus.overrun), 32'd0);
        check("t4_clr_evt_valid", 32'(bus.evt_valid), 32'd0);
        check("t4_clr_keeps_stable", 32'(bus.stable_q), 32'd1);

        // 5: match=7, 6 -> 7 held 20 cycles -> single match_hit
        bus.evt_ready = 1'b1;
        bus.match = 4'd7;
        bus.q_in = 4'd6;
        run(10);
        clear_counts();
        bus.q_in = 4'd7;
        run(20);
        check("t5_match_hit_count", 32'(n_mh), 32'd1);
        check("t5_stable_7", 32'(bus.stable_q), 32'd7);

        // 5b: WRAP_W=2 instance, five wraps saturate at 3
        clear_counts();
        for (int i = 0; i < 5; i++) begin
            bus2.q_in = 4'd3; run(10);
            bus2.q_in = 4'd1; run(10);
        end
        check("t5_w2_wrap_pulses", 32'(n_wrap2), 32'd5);
        check("t5_w2_wrap_cnt_sat", 32'(bus2.wrap_cnt), 32'd3);
        check("t5_w2_evt_data", 32'(bus2.evt_data), 32'd3);

`ifdef SEG7_EN
        // 6: q_in=8 -> seg shows 8
        bus.q_in = 4'd8;
        run(10);
        check("t6_seg8", 32'(bus.seg), 32'h7F);
`endif

        // Mid-operation reset with q_in=0: nothing committed afterwards
        bus.q_in = 4'd0;
        reset = 1'b0;
        tick(2);
        check("mid_rst_stable_q", 32'(bus.stable_q), 32'd0);
        reset = 1'b1;
        clear_counts();
        run(12);
        check("mid_rst_no_q_valid", 32'(n_qv), 32'd0);
        check("mid_rst_stable_after", 32'(bus.stable_q), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
